parity_gen_check: RTL and testbench

//  Streaming, parametrised parity generator/checker. Computes one parity bit per GROUP_W-bit group of a

---
 rtl/parity_gen_check.sv | 168 ++++++++++++++++
 tb/tb_parity_gen_check.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_gen_check.sv
// +----------------------------------------------------------------------------+
// | Module   : parity_gen_check                                                |
// | Function : streaming per-group parity generator/checker with a 2-entry     |
// |            output buffer; optional error counter under PARITY_ERR_CNT_EN   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module parity_gen_check #(
   parameter int DATA_W  = 32,
   parameter int GROUP_W = 8
`ifdef PARITY_ERR_CNT_EN
   ,
   parameter int CNT_W   = 16
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [DATA_W/GROUP_W-1:0]   in_par,
   input  logic                        odd_mode,
   input  logic                        check_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [DATA_W/GROUP_W-1:0]   out_par,
   output logic [DATA_W/GROUP_W-1:0]   out_err_vec,
   output logic                        out_err
`ifdef PARITY_ERR_CNT_EN
   ,
   input  logic                        err_cnt_clr,
   output logic [CNT_W-1:0]            err_cnt
`endif
);

   localparam int NGRP = DATA_W / GROUP_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic [DATA_W-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [NGRP-1:0]     head_par_q, head_par_d, tail_par_q, tail_par_d;
   logic [NGRP-1:0]     head_err_q, head_err_d, tail_err_q, tail_err_d;

   logic [NGRP-1:0]     par_calc;
   logic [NGRP-1:0]     err_calc;
   logic                accept;
   logic                deliver;

   genvar g;
   generate
      for (g = 0; g < NGRP; g++) begin : g_grp
         assign par_calc[g] = (^in_data[g*GROUP_W +: GROUP_W]) ^ odd_mode;
      end
   endgenerate

   assign err_calc = check_en ? (par_calc ^ in_par) : '0;
   assign accept   = in_valid && in_ready_q;
   assign deliver  = (state_q != ST_EMPTY) && out_ready;

   // Head is always the oldest beat; tail only holds a beat in ST_TWO.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_par_d  = head_par_q;
      head_err_d  = head_err_q;
      tail_data_d = tail_data_q;
      tail_par_d  = tail_par_q;
      tail_err_d  = tail_err_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d     = ST_ONE;
               head_data_d = in_data;
               head_par_d  = par_calc;
               head_err_d  = err_calc;
            end
         end
         ST_ONE: begin
            if (accept && !deliver) begin
               state_d     = ST_TWO;
               tail_data_d = in_data;
               tail_par_d  = par_calc;
               tail_err_d  = err_calc;
            end else if (accept && deliver) begin
               head_data_d = in_data;
               head_par_d  = par_calc;
               head_err_d  = err_calc;
            end else if (deliver) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (deliver) begin
               state_d     = ST_ONE;
               head_data_d = tail_data_q;
               head_par_d  = tail_par_q;
               head_err_d  = tail_err_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         head_data_q <= '0;
         head_par_q  <= '0;
         head_err_q  <= '0;
         tail_data_q <= '0;
         tail_par_q  <= '0;
         tail_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         head_data_q <= head_data_d;
         head_par_q  <= head_par_d;
         head_err_q  <= head_err_d;
         tail_data_q <= tail_data_d;
         tail_par_q  <= tail_par_d;
         tail_err_q  <= tail_err_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != ST_EMPTY);
   assign out_data    = head_data_q;
   assign out_par     = head_par_q;
   assign out_err_vec = head_err_q;
   assign out_err     = |head_err_q;

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Counted at acceptance so backpressure never delays or hides an error.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr) begin
         err_cnt_d = '0;
      end else if (accept && (|err_calc) && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_gen_check.sv
// Testbench for parity_gen_check: directed vector table, backpressure/reset
// sequences, and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_parity_gen_check;

   localparam int DW = 32;
   localparam int NG = 4;
`ifdef PARITY_ERR_CNT_EN
   localparam int CW = 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          odd_mode = 1'b0;
   logic          check_en = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [NG-1:0] in_par = '0;
   logic          in_ready, out_valid, out_err;
   logic [DW-1:0] out_data;
   logic [NG-1:0] out_par, out_err_vec;
`ifdef PARITY_ERR_CNT_EN
   logic          err_cnt_clr = 1'b0;
   logic [CW-1:0] err_cnt;
`endif

   always #5 clk = ~clk;

   parity_gen_check #(
      .DATA_W  (DW),
      .GROUP_W (8)
`ifdef PARITY_ERR_CNT_EN
      ,
      .CNT_W   (CW)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_par      (in_par),
      .odd_mode    (odd_mode),
      .check_en    (check_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_par     (out_par),
      .out_err_vec (out_err_vec),
      .out_err     (out_err)
`ifdef PARITY_ERR_CNT_EN
      ,
      .err_cnt_clr (err_cnt_clr),
      .err_cnt     (err_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference parity: population count of each byte, odd count -> 1.
   function automatic logic [NG-1:0] ref_par(input logic [DW-1:0] d, input logic odd);
      logic [NG-1:0] r;
      for (int gi = 0; gi < NG; gi++) begin
         r[gi] = (($countones(d[gi*8 +: 8]) % 2) == 1) ^ odd;
      end
      return r;
   endfunction

   typedef struct {
      logic [DW-1:0] d;
      logic [NG-1:0] p;
      logic [NG-1:0] e;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic [NG-1:0] mon_p;
   int   cnt_m = 0;
   bit   mon_en = 1'b0;
   bit   acc_flag = 1'b0;

   // Scoreboard: queue occupancy models the buffer; order and contents checked on delivery.
   always @(negedge clk) begin
      if (mon_en) begin
         acc_flag = in_valid && in_ready;
         check("in_ready", in_ready, q.size() < 2);
         check("out_valid", out_valid, q.size() > 0);
`ifdef PARITY_ERR_CNT_EN
         check("err_cnt", err_cnt, cnt_m);
`endif
         if (rst) begin
            q.delete();
            cnt_m    = 0;
            acc_flag = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("spurious_beat", 1, 0);
               end else begin
                  mon_e = q.pop_front();
                  check("out_data", out_data, mon_e.d);
                  check("out_par", out_par, mon_e.p);
                  check("out_err_vec", out_err_vec, mon_e.e);
                  check("out_err", out_err, mon_e.e != 0);
               end
            end
            mon_p = ref_par(in_data, odd_mode);
            if (acc_flag) begin
               mon_e.d = in_data;
               mon_e.p = mon_p;
               mon_e.e = check_en ? (mon_p ^ in_par) : '0;
               q.push_back(mon_e);
            end
`ifdef PARITY_ERR_CNT_EN
            if (err_cnt_clr) cnt_m = 0;
            else if (acc_flag && check_en && ((mon_p ^ in_par) != 0) && cnt_m < 3) cnt_m++;
`endif
         end
      end
   end

   task automatic drive(input logic [DW-1:0] d, input logic [NG-1:0] p, input logic odd, input logic chk);
      bit ok = 1'b0;
      in_data  = d;
      in_par   = p;
      odd_mode = odd;
      check_en = chk;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic [NG-1:0] p;
      logic          odd;
      logic          chk;
      logic [NG-1:0] exp_par;
      logic [NG-1:0] exp_ev;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h0000_0002, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000};
      vecs[1] = '{32'h0000_001E, 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000};
      vecs[2] = '{32'hFF00_FF01, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000};
      vecs[3] = '{32'hFF00_FF01, 4'b0011, 1'b0, 1'b1, 4'b0001, 4'b0010};
      vecs[4] = '{32'h8040_2010, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000};
      vecs[5] = '{32'h0F0F_0F0F, 4'b1111, 1'b0, 1'b1, 4'b0000, 4'b1111};
      vecs[6] = '{32'hFFFF_FFFF, 4'b1010, 1'b1, 1'b0, 4'b1111, 4'b0000};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_par", out_par, 0);
      check("rst_out_err", out_err, 0);

      // Directed table, one beat at a time into an empty buffer.
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].d, vecs[i].p, vecs[i].odd, vecs[i].chk);
         @(negedge clk);
         check("vec_valid", out_valid, 1);
         check("vec_par", out_par, vecs[i].exp_par);
         check("vec_err_vec", out_err_vec, vecs[i].exp_ev);
         check("vec_err", out_err, vecs[i].exp_ev != 0);
      end
`ifdef PARITY_ERR_CNT_EN
      check("cnt_after_table", err_cnt, 2);
`endif

      // Backpressure: third beat must wait until the buffer drains.
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hAAAA_0001;
      check_en = 1'b0;
      odd_mode = 1'b0;
      @(posedge clk);
      #1 in_data = 32'hBBBB_0002;
      @(posedge clk);
      #1 check("bp_in_ready_after2", in_ready, 0);
      in_data = 32'hCCCC_0003;
      repeat (3) @(posedge clk);
      #1 check("bp_in_ready_held", in_ready, 0);
      check("bp_head_stable", out_data, 32'hAAAA_0001);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("bp_drained", q.size(), 0);

      // Reset with the buffer full of errored beats.
      out_ready = 1'b0;
      drive(32'h0000_0001, 4'b0000, 1'b0, 1'b1);
      drive(32'h0000_0003, 4'b1111, 1'b0, 1'b1);
      check("pre_rst_full", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_err_vec", out_err_vec, 0);
`ifdef PARITY_ERR_CNT_EN
      check("mid_rst_err_cnt", err_cnt, 0);
`endif
      out_ready = 1'b1;
      drive(32'h0000_0007, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      check("post_rst_par", out_par, 4'b0001);

`ifdef PARITY_ERR_CNT_EN
      // Saturation at all-ones, then clear beating a simultaneous increment.
      for (int i = 0; i < 5; i++) drive(32'h0000_0000, 4'b0001, 1'b0, 1'b1);
      @(negedge clk);
      check("cnt_saturate", err_cnt, 3);
      @(posedge clk);
      #1 err_cnt_clr = 1'b1;
      drive(32'h0000_0000, 4'b0001, 1'b0, 1'b1);
      err_cnt_clr = 1'b0;
      @(negedge clk);
      check("cnt_clr_wins", err_cnt, 0);
`endif

      // Randomized traffic; producer holds a beat until it is accepted.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 299) == 0) rst = 1'b1;
         if (!in_valid || acc_flag) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            in_par   = NG'($urandom);
            odd_mode = 1'($urandom);
            check_en = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef PARITY_ERR_CNT_EN
         err_cnt_clr = ($urandom_range(0, 63) == 0);
`endif
      end
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
`ifdef PARITY_ERR_CNT_EN
      err_cnt_clr = 1'b0;
`endif
      repeat (6) @(posedge clk);
      #1 check("final_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
